// File: rtl/lfsr_checker_pkg.sv
// Shared definitions for the 8-bit LFSR generator and checker.
// Holds the checker FSM encoding and the LFSR next-state function.
package lfsr_checker_pkg;

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    // x^8+x^6+x^5+x^4+1, left shift, feedback into the LSB
    function automatic logic [7:0] lfsr8_next(input logic [7:0] x);
        return {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
    endfunction

endpackage

// File: rtl/lfsr_checker.sv
// Synchronizes to an observed 8-bit LFSR stream, then counts
// mismatches against a free-running reference while locked.
module lfsr_checker
    import lfsr_checker_pkg::*;
#(
    parameter int LOCK_COUNT = 4,
    parameter int LOSS_COUNT = 3,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_in,
    input  logic [7:0]       data_in,
    input  logic             clear_cnt,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_count
);

    localparam logic [3:0]       LOCK_N  = 4'(LOCK_COUNT);
    localparam logic [3:0]       LOSS_N  = 4'(LOSS_COUNT);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           state_q, state_d;
    logic [7:0]       exp_q, exp_d;
    logic [3:0]       run_q, run_d;
    logic             locked_q, locked_d;
    logic             err_pulse_q, err_pulse_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [3:0]       run_inc;

    always_comb begin
        state_d     = state_q;
        exp_d       = exp_q;
        run_d       = run_q;
        err_pulse_d = 1'b0;
        err_cnt_d   = err_cnt_q;
        run_inc     = run_q + 4'd1;

        if (valid_in) begin
            unique case (state_q)
                ST_HUNT: begin
                    if (data_in != 8'h00) begin
                        exp_d   = lfsr8_next(data_in);
                        run_d   = 4'd0;
                        state_d = ST_VERIFY;
                    end
                end
                ST_VERIFY: begin
                    if (data_in == 8'h00) begin
                        run_d   = 4'd0;
                        state_d = ST_HUNT;
                    end else if (data_in == exp_q) begin
                        exp_d = lfsr8_next(data_in);
                        if (run_inc == LOCK_N) begin
                            run_d   = 4'd0;
                            state_d = ST_LOCKED;
                        end else begin
                            run_d = run_inc;
                        end
                    end else begin
                        exp_d = lfsr8_next(data_in);
                        run_d = 4'd0;
                    end
                end
                ST_LOCKED: begin
                    // Reference free-runs so single errors never resync
                    exp_d = lfsr8_next(exp_q);
                    if (data_in == exp_q) begin
                        run_d = 4'd0;
                    end else begin
                        err_pulse_d = 1'b1;
                        if (err_cnt_q != CNT_MAX) begin
                            err_cnt_d = err_cnt_q + CNT_W'(1);
                        end
                        if (run_inc == LOSS_N) begin
                            run_d   = 4'd0;
                            state_d = ST_HUNT;
                        end else begin
                            run_d = run_inc;
                        end
                    end
                end
                default: begin
                    run_d   = 4'd0;
                    state_d = ST_HUNT;
                end
            endcase
        end

        if (clear_cnt) begin
            err_cnt_d = '0;
        end

        locked_d = (state_d == ST_LOCKED);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_HUNT;
            exp_q       <= 8'h00;
            run_q       <= 4'd0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            exp_q       <= exp_d;
            run_q       <= run_d;
            locked_q    <= locked_d;
            err_pulse_q <= err_pulse_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign locked    = locked_q;
    assign err_pulse = err_pulse_q;
    assign err_count = err_cnt_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// Bench for lfsr_checker: two configurations against a behavioural
// model, plus directed literal expectations.
module tb_lfsr_checker;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       valid_in = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       clear_cnt = 1'b0;

    logic        a_locked, a_pulse;
    logic [15:0] a_cnt;
    logic        b_locked, b_pulse;
    logic [1:0]  b_cnt;

    int total = 0;
    int bad   = 0;

    lfsr_checker #(.LOCK_COUNT(4), .LOSS_COUNT(3), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .valid_in(valid_in), .data_in(data_in),
        .clear_cnt(clear_cnt), .locked(a_locked), .err_pulse(a_pulse),
        .err_count(a_cnt)
    );

    lfsr_checker #(.LOCK_COUNT(4), .LOSS_COUNT(15), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .valid_in(valid_in), .data_in(data_in),
        .clear_cnt(clear_cnt), .locked(b_locked), .err_pulse(b_pulse),
        .err_count(b_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int   mode;
        int   exp;
        int   hits;
        int   misses;
        int   cnt;
        bit   pulse;
    } mdl_t;

    mdl_t ma = '{0, 0, 0, 0, 0, 1'b0};
    mdl_t mb = '{0, 0, 0, 0, 0, 1'b0};

    function automatic int nxt(input int x);
        int t;
        int p;
        t = x & 8'hB8;
        p = 0;
        for (int i = 0; i < 8; i++) p = p ^ ((t >> i) & 1);
        return ((x * 2) % 256) + p;
    endfunction

    // mode 0 = searching, 1 = confirming, 2 = synchronized
    function automatic mdl_t step(input mdl_t m, input bit v, input int d,
                                  input bit clr, input int lockc,
                                  input int lossc, input int cmax);
        mdl_t r;
        r = m;
        r.pulse = 1'b0;
        if (v) begin
            if (m.mode == 0) begin
                if (d != 0) begin
                    r.mode = 1; r.exp = nxt(d); r.hits = 0;
                end
            end else if (m.mode == 1) begin
                if (d == 0) begin
                    r.mode = 0; r.hits = 0;
                end else if (d == m.exp) begin
                    r.exp = nxt(d); r.hits = m.hits + 1;
                    if (r.hits >= lockc) begin
                        r.mode = 2; r.misses = 0;
                    end
                end else begin
                    r.exp = nxt(d); r.hits = 0;
                end
            end else begin
                r.exp = nxt(m.exp);
                if (d == m.exp) begin
                    r.misses = 0;
                end else begin
                    r.pulse = 1'b1;
                    r.cnt = (m.cnt >= cmax) ? cmax : m.cnt + 1;
                    r.misses = m.misses + 1;
                    if (r.misses >= lossc) begin
                        r.mode = 0; r.misses = 0;
                    end
                end
            end
        end
        if (clr) r.cnt = 0;
        return r;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ma = '{0, 0, 0, 0, 0, 1'b0};
            mb = '{0, 0, 0, 0, 0, 1'b0};
        end else begin
            ma = step(ma, valid_in, int'(data_in), clear_cnt, 4, 3, 65535);
            mb = step(mb, valid_in, int'(data_in), clear_cnt, 4, 15, 3);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d t=%0t",
                     name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("a_locked", int'(a_locked), int'(ma.mode == 2));
        chk("a_pulse", int'(a_pulse), int'(ma.pulse));
        chk("a_cnt", int'(a_cnt), ma.cnt);
        chk("b_locked", int'(b_locked), int'(mb.mode == 2));
        chk("b_pulse", int'(b_pulse), int'(mb.pulse));
        chk("b_cnt", int'(b_cnt), mb.cnt);
    end

    task automatic drv(input bit v, input logic [7:0] d, input bit c);
        @(negedge clk);
        valid_in  = v;
        data_in   = d;
        clear_cnt = c;
        @(posedge clk);
        #1;
        valid_in  = 1'b0;
        clear_cnt = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    logic [7:0] gen;

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_locked", int'(a_locked), 0);
        chk("rst_cnt", int'(a_cnt), 0);

        drv(1, 8'hAB, 0);
        drv(1, 8'h57, 0);
        drv(1, 8'hAF, 0);
        drv(1, 8'h5F, 0);
        chk("prelock", int'(a_locked), 0);
        drv(1, 8'hBE, 0);
        chk("lock_a", int'(a_locked), 1);
        chk("lock_b", int'(b_locked), 1);
        chk("lock_cnt", int'(a_cnt), 0);
        gen = 8'hBE;

        gen = 8'h7C;
        drv(1, 8'h00, 0);
        chk("err_pulse", int'(a_pulse), 1);
        chk("err_cnt1", int'(a_cnt), 1);
        chk("err_locked", int'(a_locked), 1);
        for (int i = 0; i < 3; i++) begin
            gen = 8'(nxt(int'(gen)));
            drv(1, gen, 0);
        end
        chk("pulse_once", int'(a_pulse), 0);
        chk("cnt_hold", int'(a_cnt), 1);
        chk("still_lock", int'(a_locked), 1);

        for (int i = 0; i < 3; i++) begin
            gen = 8'(nxt(int'(gen)));
            drv(1, ~gen, 0);
            if (i == 1) chk("loss_mid", int'(a_locked), 1);
        end
        chk("loss_lock", int'(a_locked), 0);
        chk("loss_cnt", int'(a_cnt), 4);
        chk("b_keep", int'(b_locked), 1);
        chk("b_sat3", int'(b_cnt), 3);

        for (int i = 0; i < 2; i++) begin
            gen = 8'(nxt(int'(gen)));
            drv(1, ~gen, 0);
        end
        chk("b_sat5", int'(b_cnt), 3);
        gen = 8'(nxt(int'(gen)));
        drv(1, ~gen, 1);
        chk("b_clear", int'(b_cnt), 0);
        chk("b_clr_pulse", int'(b_pulse), 1);

        do_reset();
        drv(1, 8'h00, 0);
        drv(1, 8'hAB, 0);
        drv(0, 8'h11, 0);
        drv(1, 8'h57, 0);
        drv(0, 8'h22, 0);
        drv(1, 8'hAF, 0);
        drv(0, 8'h33, 0);
        drv(1, 8'h5F, 0);
        drv(0, 8'h44, 0);
        drv(0, 8'h55, 0);
        chk("gap_prelock", int'(a_locked), 0);
        drv(1, 8'hBE, 0);
        chk("gap_lock", int'(a_locked), 1);
        gen = 8'hBE;

        for (int i = 0; i < 2; i++) begin
            gen = 8'(nxt(int'(gen)));
            drv(1, ~gen, 0);
        end
        chk("pre_rst_cnt", int'(a_cnt), 2);
        chk("pre_rst_lock", int'(a_locked), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_lock", int'(a_locked), 0);
        chk("arst_cnt", int'(a_cnt), 0);
        chk("arst_pulse", int'(a_pulse), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        gen = 8'h01;
        for (int i = 0; i < 40; i++) begin
            gen = 8'(nxt(int'(gen)));
            if (i % 9 == 8) drv(1, gen ^ 8'h04, (i % 18) == 17);
            else if (i % 5 == 3) drv(0, 8'hFF, 0);
            else drv(1, gen, 0);
        end

        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
